// File: rtl/polar_encoder.sv
// Sequential polar encoder: one info/frozen allocation per cycle, then one
// butterfly stage per cycle over the whole codeword register.
module polar_encoder #(
  parameter int N     = 1024,
  parameter int LOG2N = 10,
  parameter int K     = 512
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [K-1:0] in_data,
  input  logic [N-1:0] in_frozen,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_codeword,
  output logic         out_mismatch,
  output logic [1:0]   state_dbg
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both 1; in_valid is looked at only in IDLE and out_ready only in DONE.
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ALLOC = 2'd1;
  localparam logic [1:0] ENC   = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam logic [LOG2N:0]   K_CNT    = (LOG2N+1)'(K);
  localparam logic [LOG2N-1:0] IDX_LAST = (LOG2N)'(N-1);
  localparam logic [LOG2N-1:0] S_LAST   = (LOG2N)'(LOG2N-1);

  logic [1:0]       state;
  logic [LOG2N-1:0] idx;
  logic [LOG2N-1:0] s;
  logic [LOG2N:0]   used;
  logic [LOG2N:0]   unfrozen;
  logic [K-1:0]     info;
  logic [N-1:0]     mask;
  logic [N-1:0]     x;
  logic [N-1:0]     lo_mask;
  logic [N-1:0]     stage_x;
  logic             take;

  // lo_mask marks the indices whose bit s is 0; those absorb x[i + 2^s].
  always_comb begin
    lo_mask = '0;
    for (int i = 0; i < N; i++) begin
      lo_mask[i] = ((i >> s) & 1) == 0;
    end
    stage_x = x ^ ((x >> (32'd1 << s)) & lo_mask);
  end

  assign take = !mask[idx] && (used < K_CNT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      idx      <= '0;
      s        <= '0;
      used     <= '0;
      unfrozen <= '0;
      info     <= '0;
      mask     <= '0;
      x        <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            info     <= in_data;
            mask     <= in_frozen;
            x        <= '0;
            idx      <= '0;
            used     <= '0;
            unfrozen <= '0;
            state    <= ALLOC;
          end
        end
        ALLOC: begin
          x[idx] <= take & info[0];
          if (take) begin
            info <= info >> 1;
            used <= used + 1'b1;
          end
          if (!mask[idx]) unfrozen <= unfrozen + 1'b1;
          if (idx == IDX_LAST) begin
            idx   <= '0;
            s     <= '0;
            state <= ENC;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        ENC: begin
          x <= stage_x;
          if (s == S_LAST) begin
            s     <= '0;
            state <= DONE;
          end else begin
            s <= s + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready     = (state == IDLE);
  assign out_valid    = (state == DONE);
  assign out_codeword = x;
  assign out_mismatch = (state == DONE) && (unfrozen != K_CNT);
  assign state_dbg    = state;

endmodule

// File: tb/tb_polar_encoder.sv
// Directed + random bench for polar_encoder at N=8, K=4, with an expected queue
// of {mismatch, codeword} entries pushed on accept and popped on output.
module tb_polar_encoder;
  localparam int N     = 8;
  localparam int LOG2N = 3;
  localparam int K     = 4;
  localparam int LAT   = N + LOG2N;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [K-1:0] in_data;
  logic [N-1:0] in_frozen;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] out_codeword;
  logic         out_mismatch;
  logic [1:0]   state_dbg;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int accept_cyc = 0;
  logic [N:0] exp_q[$];

  polar_encoder #(.N(N), .LOG2N(LOG2N), .K(K)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_frozen(in_frozen),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_codeword(out_codeword), .out_mismatch(out_mismatch),
    .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // Reference: allocate u, then x[i] = XOR of u[j] over all supersets j of i.
  function automatic logic [N:0] model(input logic [N-1:0] frz, input logic [K-1:0] data);
    logic [N-1:0] u;
    logic [N-1:0] xv;
    int used;
    int cnt;
    u = '0;
    xv = '0;
    used = 0;
    cnt = 0;
    for (int i = 0; i < N; i++) begin
      if (!frz[i]) begin
        cnt++;
        if (used < K) begin
          u[i] = data[used];
          used++;
        end
      end
    end
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        if ((j & i) == i) xv[i] = xv[i] ^ u[j];
      end
    end
    return {cnt != K, xv};
  endfunction

  // driver tasks: called and returning at a falling edge
  task automatic send(input logic [N-1:0] frz, input logic [K-1:0] data, input bit keep);
    int w;
    in_frozen = frz;
    in_data   = data;
    in_valid  = 1'b1;
    w = 0;
    while (!in_ready && w < 200) begin
      @(negedge clk);
      w++;
    end
    chk("in_ready_before_accept", in_ready, 1);
    accept_cyc = cyc + 1;
    @(negedge clk);
    if (!keep) in_valid = 1'b0;
    chk("in_ready_low_after_accept", in_ready, 0);
  endtask

  task automatic get(input int hold);
    int w;
    logic [N-1:0] cw;
    logic [N:0]   e;
    w = 0;
    while (!out_valid && w < 200) begin
      @(negedge clk);
      w++;
    end
    chk("out_valid_rise", out_valid, 1);
    chk("latency", cyc - accept_cyc, LAT);
    cw = out_codeword;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk("hold_out_valid", out_valid, 1);
      chk("hold_codeword", out_codeword, cw);
      chk("hold_in_ready", in_ready, 0);
    end
    chk("queue_nonempty", exp_q.size(), (exp_q.size() > 0) ? exp_q.size() : 1);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    chk("codeword", out_codeword, e[N-1:0]);
    chk("mismatch", out_mismatch, e[N]);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("in_ready_after_handshake", in_ready, 1);
    chk("out_valid_after_handshake", out_valid, 0);
  endtask

  initial begin
    bit seen;
    logic [N-1:0] rf;
    logic [K-1:0] rd;

    rst = 1'b1;
    in_valid = 1'b0;
    in_data = '0;
    in_frozen = '0;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_in_ready", in_ready, 1);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_codeword", out_codeword, 0);
    chk("reset_mismatch", out_mismatch, 0);
    chk("reset_state", state_dbg, 0);
    rst = 1'b0;

    // first in_valid after reset is accepted
    exp_q.push_back({1'b0, 8'h96});
    send(8'h17, 4'b1111, 1'b0);
    get(0);

    exp_q.push_back({1'b0, 8'h0F});
    send(8'h17, 4'b0001, 1'b0);
    get(0);

    exp_q.push_back({1'b1, 8'h78});
    send(8'h07, 4'b1111, 1'b0);
    get(1);

    // downstream stall in DONE
    exp_q.push_back({1'b0, 8'h96});
    send(8'h17, 4'b1111, 1'b0);
    get(20);

    // back-to-back with in_valid held high; out_ready high early has no effect
    exp_q.push_back({1'b0, 8'h96});
    send(8'h17, 4'b1111, 1'b1);
    in_data = 4'b0001;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("early_ready_no_effect", state_dbg, 1);
    out_ready = 1'b0;
    get(2);
    exp_q.push_back({1'b0, 8'h0F});
    accept_cyc = cyc + 1;
    @(negedge clk);
    in_valid = 1'b0;
    chk("b2b_second_accepted", in_ready, 0);
    get(0);

    // reset during ENC stage 1 abandons the frame
    send(8'h17, 4'b1111, 1'b0);
    repeat (N + 1) @(negedge clk);
    chk("at_enc_before_reset", state_dbg, 2);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midreset_in_ready", in_ready, 1);
    chk("midreset_codeword", out_codeword, 0);
    seen = 1'b0;
    in_valid = 1'b0;
    repeat (LAT + 5) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    chk("no_output_after_reset", seen, 0);
    exp_q.push_back({1'b0, 8'h96});
    send(8'h17, 4'b1111, 1'b0);
    get(0);

    // random frames
    for (int r = 0; r < 6; r++) begin
      rf = 8'($urandom_range(0, 255));
      rd = 4'($urandom_range(0, 15));
      exp_q.push_back(model(rf, rd));
      send(rf, rd, 1'b0);
      get($urandom_range(0, 3));
    end

    chk("queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
